// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I sequencer: FETCH -> EXEC -> (MEM) -> FETCH, traps on illegal opcodes or bus timeouts.
// Latency: fetch cycles + 1 (+ mem cycles for LW/SW); a req is held until ack, or until TIMEOUT cycles pass, then it traps.
module multicycle_controller #(
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rset,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    input  logic        beq,
    output logic        pc_en,
    output logic        pc_sel,
    output logic [2:0]  imm_sel,
    output logic        RF_we,
    output logic        a_sel,
    output logic        b_sel,
    output logic [3:0]  alu_sel,
    output logic [1:0]  wb_sel,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        halted,
    output logic [1:0]  trap_cause,
    output logic [31:0] instret
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {FETCH, EXEC, MEM, TRAP} state_t;

    state_t        state;
    logic [31:0]   ir;
    logic [CW-1:0] wait_cnt;

    logic       d_legal, d_mem, d_store, d_branch;
    logic       d_a, d_b, d_pc_sel;
    logic [2:0] d_imm;
    logic [3:0] d_alu;
    logic [1:0] d_wb;

    wire [6:0] opcode = ir[6:0];
    wire [2:0] funct3 = ir[14:12];
    wire [6:0] funct7 = ir[31:25];

    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    alu_of = alt ? 4'd1 : 4'd0;
            3'd1:    alu_of = 4'd2;
            3'd2:    alu_of = 4'd3;
            3'd3:    alu_of = 4'd4;
            3'd4:    alu_of = 4'd5;
            3'd5:    alu_of = alt ? 4'd7 : 4'd6;
            3'd6:    alu_of = 4'd8;
            default: alu_of = 4'd9;
        endcase
    endfunction

    always_comb begin
        d_legal  = 1'b0;
        d_mem    = 1'b0;
        d_store  = 1'b0;
        d_branch = 1'b0;
        d_a      = 1'b0;
        d_b      = 1'b0;
        d_pc_sel = 1'b0;
        d_imm    = 3'd0;
        d_alu    = 4'd0;
        d_wb     = 2'd0;
        case (opcode)
            7'b0110011: begin
                d_legal = (funct7 == 7'h00) ||
                          (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5));
                d_alu   = alu_of(funct3, funct7[5]);
                d_wb    = 2'd1;
            end
            7'b0010011: begin
                // only the shift-immediates carry a funct7 field
                case (funct3)
                    3'd1:    d_legal = (funct7 == 7'h00);
                    3'd5:    d_legal = (funct7 == 7'h00) || (funct7 == 7'h20);
                    default: d_legal = 1'b1;
                endcase
                d_alu = alu_of(funct3, (funct3 == 3'd5) && funct7[5]);
                d_b   = 1'b1;
                d_wb  = 2'd1;
            end
            7'b0110111: begin
                d_legal = 1'b1;
                d_imm   = 3'd3;
                d_b     = 1'b1;
                d_alu   = 4'd10;
                d_wb    = 2'd1;
            end
            7'b0010111: begin
                d_legal = 1'b1;
                d_imm   = 3'd3;
                d_a     = 1'b1;
                d_b     = 1'b1;
                d_wb    = 2'd1;
            end
            7'b1101111: begin
                d_legal  = 1'b1;
                d_imm    = 3'd4;
                d_a      = 1'b1;
                d_b      = 1'b1;
                d_pc_sel = 1'b1;
                d_wb     = 2'd2;
            end
            7'b1100111: begin
                d_legal  = (funct3 == 3'd0);
                d_b      = 1'b1;
                d_pc_sel = 1'b1;
                d_wb     = 2'd2;
            end
            7'b1100011: begin
                d_legal  = (funct3 == 3'd0) || (funct3 == 3'd1);
                d_branch = 1'b1;
                d_imm    = 3'd2;
                d_a      = 1'b1;
                d_b      = 1'b1;
                d_pc_sel = funct3[0] ? !beq : beq;
            end
            7'b0000011: begin
                d_legal = (funct3 == 3'd2);
                d_mem   = 1'b1;
                d_b     = 1'b1;
            end
            7'b0100011: begin
                d_legal = (funct3 == 3'd2);
                d_mem   = 1'b1;
                d_store = 1'b1;
                d_imm   = 3'd1;
                d_b     = 1'b1;
            end
            default: d_legal = 1'b0;
        endcase
    end

    always_comb begin
        imem_req = 1'b0;
        pc_en    = 1'b0;
        pc_sel   = 1'b0;
        imm_sel  = 3'd0;
        RF_we    = 1'b0;
        a_sel    = 1'b0;
        b_sel    = 1'b0;
        alu_sel  = 4'd0;
        wb_sel   = 2'd0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        halted   = 1'b0;
        case (state)
            FETCH: imem_req = 1'b1;
            EXEC: if (d_legal) begin
                imm_sel = d_imm;
                a_sel   = d_a;
                b_sel   = d_b;
                alu_sel = d_alu;
                wb_sel  = d_wb;
                pc_sel  = d_pc_sel;
                RF_we   = !d_mem && !d_branch;
                pc_en   = !d_mem;
            end
            MEM: begin
                imm_sel  = d_imm;
                a_sel    = d_a;
                b_sel    = d_b;
                alu_sel  = d_alu;
                dmem_req = 1'b1;
                dmem_we  = d_store;
                pc_en    = dmem_ack;
                RF_we    = dmem_ack && !d_store;
            end
            default: halted = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rset) begin
            state      <= FETCH;
            ir         <= NOP_INST;
            instret    <= 32'd0;
            wait_cnt   <= '0;
            trap_cause <= 2'd0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ack) begin
                        ir       <= imem_rdata;
                        state    <= EXEC;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state      <= TRAP;
                        trap_cause <= 2'd2;
                        wait_cnt   <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                EXEC: begin
                    wait_cnt <= '0;
                    if (!d_legal) begin
                        state      <= TRAP;
                        trap_cause <= 2'd1;
                    end else if (d_mem) begin
                        state <= MEM;
                    end else begin
                        instret <= instret + 32'd1;
                        state   <= FETCH;
                    end
                end
                MEM: begin
                    if (dmem_ack) begin
                        instret  <= instret + 32'd1;
                        state    <= FETCH;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state      <= TRAP;
                        trap_cause <= 2'd3;
                        wait_cnt   <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= TRAP;
            endcase
        end
    end

    assign inst = ir;
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller (TIMEOUT=4): decode vectors, memory handshakes, traps, mid-flight reset.
module tb_multicycle_controller;
    logic        clk = 1'b0;
    logic        rset, imem_ack, beq, dmem_ack;
    logic [31:0] imem_rdata;
    logic        imem_req, pc_en, pc_sel, RF_we, a_sel, b_sel, dmem_req, dmem_we, halted;
    logic [2:0]  imm_sel;
    logic [3:0]  alu_sel;
    logic [1:0]  wb_sel, trap_cause;
    logic [31:0] inst, instret;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_ret;

    localparam logic [31:0] I_ADDI = 32'h0050_0093;
    localparam logic [31:0] I_SUB  = 32'h4020_81B3;
    localparam logic [31:0] I_SRAI = 32'h4030_D093;
    localparam logic [31:0] I_LUI  = 32'h1234_52B7;
    localparam logic [31:0] I_JAL  = 32'h0000_00EF;
    localparam logic [31:0] I_JALR = 32'h0001_00E7;
    localparam logic [31:0] I_BEQ  = 32'h0000_0063;
    localparam logic [31:0] I_BNE  = 32'h0000_1063;
    localparam logic [31:0] I_LW   = 32'h0000_2203;
    localparam logic [31:0] I_SW   = 32'h0000_2023;

    multicycle_controller #(.TIMEOUT(4)) dut (
        .clk(clk), .rset(rset), .imem_req(imem_req), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .inst(inst), .beq(beq), .pc_en(pc_en),
        .pc_sel(pc_sel), .imm_sel(imm_sel), .RF_we(RF_we), .a_sel(a_sel),
        .b_sel(b_sel), .alu_sel(alu_sel), .wb_sel(wb_sel), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_ack(dmem_ack), .halted(halted),
        .trap_cause(trap_cause), .instret(instret)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // {pc_en,pc_sel,imm_sel,RF_we,a_sel,b_sel,alu_sel,wb_sel,dmem_req,dmem_we}
    function automatic logic [15:0] ctl_vec(input logic pe, input logic ps, input logic [2:0] im,
                                            input logic rf, input logic a, input logic b,
                                            input logic [3:0] alu, input logic [1:0] wb,
                                            input logic dr, input logic dw);
        return {pe, ps, im, rf, a, b, alu, wb, dr, dw};
    endfunction

    function automatic logic [15:0] ctl_now();
        return {pc_en, pc_sel, imm_sel, RF_we, a_sel, b_sel, alu_sel, wb_sel, dmem_req, dmem_we};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rset = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; beq = 1'b0; imem_rdata = 32'h0;
        step();
        rset = 1'b0;
        exp_ret = 32'd0;
    endtask

    task automatic fetch(input logic [31:0] ins, input int w);
        for (int i = 0; i < w; i++) begin
            imem_ack = 1'b0;
            @(negedge clk);
            chk("fetch_wait_req", {31'd0, imem_req}, 32'd1);
            step();
        end
        imem_ack = 1'b1;
        imem_rdata = ins;
        @(negedge clk);
        chk("fetch_ctl", {16'd0, ctl_now()}, 32'd0);
        step();
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        chk("ir_load", inst, ins);
    endtask

    task automatic run_one(input string tag, input logic [31:0] ins, input int w,
                           input logic b, input logic [15:0] exp_ctl);
        fetch(ins, w);
        beq = b;
        @(negedge clk);
        chk(tag, {16'd0, ctl_now()}, {16'd0, exp_ctl});
        step();
        beq = 1'b0;
        exp_ret = exp_ret + 32'd1;
        chk("instret", instret, exp_ret);
    endtask

    initial begin
        do_reset();
        @(negedge clk);
        chk("rst_ir", inst, 32'h0000_0013);
        chk("rst_instret", instret, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_cause", {30'd0, trap_cause}, 32'd0);
        chk("rst_ctl", {16'd0, ctl_now()}, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd1);
        step();

        run_one("addi", I_ADDI, 0, 1'b0, ctl_vec(1, 0, 0, 1, 0, 1, 0,  1, 0, 0));
        run_one("sub",  I_SUB,  2, 1'b0, ctl_vec(1, 0, 0, 1, 0, 0, 1,  1, 0, 0));
        run_one("srai", I_SRAI, 3, 1'b0, ctl_vec(1, 0, 0, 1, 0, 1, 7,  1, 0, 0));
        run_one("lui",  I_LUI,  1, 1'b0, ctl_vec(1, 0, 3, 1, 0, 1, 10, 1, 0, 0));
        run_one("jal",  I_JAL,  0, 1'b0, ctl_vec(1, 1, 4, 1, 1, 1, 0,  2, 0, 0));
        run_one("jalr", I_JALR, 0, 1'b0, ctl_vec(1, 1, 0, 1, 0, 1, 0,  2, 0, 0));
        run_one("beq_taken",  I_BEQ, 0, 1'b1, ctl_vec(1, 1, 2, 0, 1, 1, 0, 0, 0, 0));
        run_one("bne_not",    I_BNE, 0, 1'b1, ctl_vec(1, 0, 2, 0, 1, 1, 0, 0, 0, 0));
        run_one("bne_taken",  I_BNE, 0, 1'b0, ctl_vec(1, 1, 2, 0, 1, 1, 0, 0, 0, 0));

        // LW with dmem_ack in the third MEM cycle
        fetch(I_LW, 0);
        @(negedge clk);
        chk("lw_exec", {16'd0, ctl_now()}, {16'd0, ctl_vec(0, 0, 0, 0, 0, 1, 0, 0, 0, 0)});
        step();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("lw_mem_wait", {16'd0, ctl_now()}, {16'd0, ctl_vec(0, 0, 0, 0, 0, 1, 0, 0, 1, 0)});
            step();
        end
        dmem_ack = 1'b1;
        @(negedge clk);
        chk("lw_mem_ack", {16'd0, ctl_now()}, {16'd0, ctl_vec(1, 0, 0, 1, 0, 1, 0, 0, 1, 0)});
        step();
        dmem_ack = 1'b0;
        exp_ret = exp_ret + 32'd1;
        chk("lw_instret", instret, exp_ret);
        @(negedge clk);
        chk("lw_after", {16'd0, ctl_now()}, 32'd0);
        step();

        // SW acked in its first MEM cycle
        fetch(I_SW, 0);
        @(negedge clk);
        chk("sw_exec", {16'd0, ctl_now()}, {16'd0, ctl_vec(0, 0, 1, 0, 0, 1, 0, 0, 0, 0)});
        step();
        dmem_ack = 1'b1;
        @(negedge clk);
        chk("sw_mem_ack", {16'd0, ctl_now()}, {16'd0, ctl_vec(1, 0, 1, 0, 0, 1, 0, 0, 1, 1)});
        step();
        dmem_ack = 1'b0;
        exp_ret = exp_ret + 32'd1;
        chk("sw_instret", instret, exp_ret);

        // reset during the second MEM cycle of an LW
        fetch(I_LW, 0);
        step();
        @(negedge clk);
        chk("rlw_mem1_rf", {31'd0, RF_we}, 32'd0);
        step();
        rset = 1'b1;
        @(negedge clk);
        chk("rlw_mem2_rf", {31'd0, RF_we}, 32'd0);
        step();
        rset = 1'b0;
        exp_ret = 32'd0;
        chk("rlw_ir", inst, 32'h0000_0013);
        chk("rlw_instret", instret, 32'd0);
        @(negedge clk);
        chk("rlw_fetch_ctl", {16'd0, ctl_now()}, 32'd0);
        chk("rlw_fetch_req", {31'd0, imem_req}, 32'd1);
        step();

        // SW without dmem_ack: four MEM cycles then trap cause 3
        fetch(I_SW, 0);
        step();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("swto_req", {30'd0, dmem_req, halted}, 32'd2);
            step();
        end
        chk("swto_halted", {31'd0, halted}, 32'd1);
        chk("swto_cause", {30'd0, trap_cause}, 32'd3);
        chk("swto_instret", instret, 32'd0);

        // illegal instruction
        do_reset();
        fetch(32'hFFFF_FFFF, 0);
        @(negedge clk);
        chk("ill_exec", {16'd0, ctl_now()}, 32'd0);
        step();
        chk("ill_halted", {31'd0, halted}, 32'd1);
        chk("ill_cause", {30'd0, trap_cause}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            imem_ack = i[0];
            dmem_ack = i[0];
            @(negedge clk);
            chk("ill_frozen", {14'd0, imem_req, halted, ctl_now()}, 32'h0001_0000);
            step();
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        chk("ill_instret", instret, 32'd0);

        // fetch timeout: four unacknowledged FETCH cycles
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("ifto_req", {30'd0, imem_req, halted}, 32'd2);
            step();
        end
        chk("ifto_halted", {31'd0, halted}, 32'd1);
        chk("ifto_cause", {30'd0, trap_cause}, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
